// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC walker, request port, instruction FIFO, redirect/halt.
module fetch_unit #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         ADDR_WIDTH  = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, HALTED} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  discard;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic          flush;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          resp_halt;
  logic          start_ok;
  logic          outstanding_after;
  logic [CW-1:0] count_after;

  // While a dropped response is still in flight the request port stays quiet.
  assign mem_req_valid = (state == REQ) && !discard;
  assign mem_req_addr  = pc;
  assign instr_valid   = (count != '0);
  assign instr         = fifo_data[rd_ptr];
  assign instr_pc      = fifo_pc[rd_ptr];

  assign flush     = redirect_valid && (state != IDLE);
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign push      = (state == WAIT) && mem_resp_valid && !flush;
  assign pop       = instr_valid && instr_ready && !flush;
  assign resp_halt = (mem_resp_data[DATA_WIDTH-1:DATA_WIDTH-4] == HALT_OPCODE);
  assign start_ok  = start && ((state == IDLE) || (state == HALTED));

  // A response is still owed after this edge if one was just requested or one is pending and not arriving now.
  assign outstanding_after = req_fire || (((state == WAIT) || discard) && !mem_resp_valid);

  always_comb begin
    count_after = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      discard <= 1'b0;
      done    <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_resp_data;
        fifo_pc[wr_ptr]   <= pc - ADDR_WIDTH'(1);
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (instr[DATA_WIDTH-1:DATA_WIDTH-4] == HALT_OPCODE) done <= 1'b1;
      end
      count <= count_after;
      if (discard && mem_resp_valid) discard <= 1'b0;

      if (flush) begin
        state   <= REQ;
        pc      <= redirect_pc;
        done    <= 1'b0;
        discard <= outstanding_after;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
      end else if (start_ok) begin
        state  <= REQ;
        pc     <= start_pc;
        done   <= 1'b0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        case (state)
          REQ: if (req_fire) begin
            pc    <= pc + ADDR_WIDTH'(1);
            state <= WAIT;
          end
          WAIT: if (mem_resp_valid) begin
            if (resp_halt)                          state <= HALTED;
            else if (count_after < CW'(FIFO_DEPTH)) state <= REQ;
            else                                    state <= FULL;
          end
          FULL: if (pop) state <= REQ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        mem_req_valid;
  logic [7:0]  mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [15:0] mem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;
  logic        done;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] pc; logic [15:0] w;} ent_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          halt_pop_cyc = -1;
  ent_t        exp_q[$];
  logic [7:0]  exp_req[$];
  logic [15:0] prog [256];
  int          lat = 1;
  int          stall_per_req = 0;
  int          stall_left = 0;
  int          cnt = 0;
  int          resp_count = 0;
  bit          pend = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_addr = '0;
  logic [7:0]  paddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Memory model: logs accepted requests against the expected address queue and answers after lat cycles.
  always @(posedge clk) begin : mem_model
    if (rst_n) begin
      if (prev_stall && mem_req_valid) chk("stall_addr_stable", mem_req_addr, prev_addr);
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got %0h expected none", mem_req_addr);
        end else begin
          chk("req_addr", mem_req_addr, exp_req.pop_front());
        end
        pend = 1; cnt = lat; paddr = mem_req_addr; stall_left = stall_per_req;
      end
    end
    #1;
    mem_resp_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 0; mem_resp_valid = 1'b1; mem_resp_data = prog[paddr]; resp_count++;
      end
    end
    mem_req_ready = !(mem_req_valid && stall_left > 0);
    if (mem_req_valid && stall_left > 0) stall_left--;
  end

  always @(negedge clk) begin : monitor
    ent_t e;
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_instr: got pc %0h word %0h expected none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_word", instr, e.w);
      end
      if (instr[15:12] == 4'hF) halt_pop_cyc = cyc;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic add_exp(logic [7:0] pc, logic [15:0] w);
    ent_t e;
    e.pc = pc; e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    exp_q.delete(); exp_req.delete(); pend = 0; stall_per_req = 0; stall_left = 0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_start(logic [7:0] pc);
    start_pc = pc; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_redirect(logic [7:0] pc);
    redirect_pc = pc; redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_done(string name, int budget, output int dcyc);
    int n;
    n = 0;
    while (!done && n < budget) begin step(1); n++; end
    dcyc = cyc;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1 within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_drained(string name);
    chk({name, "_req_q_empty"}, exp_req.size(), 0);
    chk({name, "_instr_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dcyc;
    int n;
    int rc;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;

    // Reset state
    #2;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_done", done, 0);
    do_reset();

    // Straight-line program ending in HALT
    prog[8'h10] = 16'h1AC3; prog[8'h11] = 16'h9567; prog[8'h12] = 16'h6F12;
    prog[8'h13] = 16'hF000; prog[8'h14] = 16'h1111;
    lat = 1; instr_ready = 1'b1;
    for (int a = 8'h10; a <= 8'h13; a++) begin
      exp_req.push_back(8'(a));
      add_exp(8'(a), prog[a]);
    end
    pulse_start(8'h10);
    chk("t1_first_req_valid", mem_req_valid, 1);
    chk("t1_first_req_addr", mem_req_addr, 8'h10);
    wait_done("t1", 60, dcyc);
    chk("t1_done_latency", dcyc, halt_pop_cyc + 1);
    step(5);
    chk("t1_no_req_after_halt", mem_req_valid, 0);
    chk("t1_done_held", done, 1);
    chk_drained("t1");

    // Backpressure fills the buffer, one pop releases one request
    do_reset();
    for (int a = 0; a < 16; a++) prog[8'h30 + a] = 16'h1000 + 16'(a);
    for (int a = 8'h30; a <= 8'h33; a++) exp_req.push_back(8'(a));
    pulse_start(8'h30);
    step(15);
    chk("t2_full_no_req", mem_req_valid, 0);
    chk("t2_full_head_pc", instr_pc, 8'h30);
    chk("t2_full_head_valid", instr_valid, 1);
    chk("t2_four_reqs", exp_req.size(), 0);
    exp_req.push_back(8'h34);
    add_exp(8'h30, 16'h1000);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(6);
    chk("t2_refull_no_req", mem_req_valid, 0);
    chk("t2_new_head_pc", instr_pc, 8'h31);
    chk_drained("t2");

    // Redirect while the 0x12 request is outstanding
    do_reset();
    prog[8'h40] = 16'h4001; prog[8'h41] = 16'h4102; prog[8'h42] = 16'hF042;
    lat = 4;
    exp_req.push_back(8'h10); exp_req.push_back(8'h11); exp_req.push_back(8'h12);
    exp_req.push_back(8'h40); exp_req.push_back(8'h41); exp_req.push_back(8'h42);
    add_exp(8'h40, 16'h4001); add_exp(8'h41, 16'h4102); add_exp(8'h42, 16'hF042);
    pulse_start(8'h10);
    n = 0;
    while (exp_req.size() > 3 && n < 40) begin step(1); n++; end
    chk("t3_reached_0x12", exp_req.size(), 3);
    pulse_redirect(8'h40);
    instr_ready = 1'b1;
    chk("t3_flushed", instr_valid, 0);
    chk("t3_no_req_while_pending", mem_req_valid, 0);
    n = 0;
    while (!mem_resp_valid && n < 10) begin
      chk("t3_hold_until_resp", mem_req_valid, 0);
      step(1); n++;
    end
    chk("t3_resp_seen", mem_resp_valid, 1);
    step(1);
    chk("t3_req_after_resp", mem_req_valid, 1);
    chk("t3_req_addr_0x40", mem_req_addr, 8'h40);
    chk("t3_dropped_not_buffered", instr_valid, 0);
    wait_done("t3", 80, dcyc);
    chk_drained("t3");

    // Redirect past a buffered HALT
    do_reset();
    lat = 1;
    prog[8'h05] = 16'hF005; prog[8'h20] = 16'h2222; prog[8'h21] = 16'hF021;
    exp_req.push_back(8'h05);
    pulse_start(8'h05);
    step(6);
    chk("t4_halt_buffered", instr_valid, 1);
    chk("t4_halt_pc", instr_pc, 8'h05);
    chk("t4_halted_no_req", mem_req_valid, 0);
    exp_req.push_back(8'h20); exp_req.push_back(8'h21);
    add_exp(8'h20, 16'h2222); add_exp(8'h21, 16'hF021);
    pulse_redirect(8'h20);
    chk("t4_done_low", done, 0);
    chk("t4_req_valid", mem_req_valid, 1);
    chk("t4_req_addr", mem_req_addr, 8'h20);
    instr_ready = 1'b1;
    wait_done("t4", 40, dcyc);
    chk_drained("t4");

    // Address wrap with stalled request and 3-cycle latency
    do_reset();
    prog[8'hFF] = 16'h3333; prog[8'h00] = 16'hF100;
    lat = 3; stall_per_req = 2; stall_left = 2; instr_ready = 1'b1;
    exp_req.push_back(8'hFF); exp_req.push_back(8'h00);
    add_exp(8'hFF, 16'h3333); add_exp(8'h00, 16'hF100);
    pulse_start(8'hFF);
    chk("t5_stalled", mem_req_ready, 0);
    chk("t5_addr_ff", mem_req_addr, 8'hFF);
    wait_done("t5", 60, dcyc);
    chk_drained("t5");
    stall_per_req = 0;

    // Asynchronous reset during WAIT
    do_reset();
    lat = 5;
    prog[8'h50] = 16'h1234;
    exp_req.push_back(8'h50);
    instr_ready = 1'b1;
    pulse_start(8'h50);
    step(2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req_valid", mem_req_valid, 0);
    chk("t6_req_addr", mem_req_addr, 0);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_instr_pc", instr_pc, 0);
    chk("t6_done", done, 0);
    rc = resp_count;
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("t6_idle_instr_valid", instr_valid, 0);
      chk("t6_idle_req_valid", mem_req_valid, 0);
    end
    chk("t6_late_resp_arrived", int'(resp_count > rc), 1);
    chk_drained("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
